// File: rtl/bht_pkg.sv
// rtl/bht_pkg.sv - shared FSM encoding, sweep value and counter update rule for the BHT controller
package bht_pkg;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_UPD_WR = 2'd2;

  localparam logic [1:0] DEFAULT_INIT_CNT = 2'b01;

  // 2-bit saturating counter step toward the resolved direction
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// rtl/bht_upd_fifo.sv - synchronous FIFO holding resolved branch outcomes awaiting their RMW
module bht_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bht_controller.sv
// rtl/bht_controller.sv - BHT RAM sequencer: init/flush sweep, lookup/update arbitration, counter RMW
module bht_controller
  import bht_pkg::*;
#(
  parameter int         MEM_SIZE  = 1024,
  parameter int         IDX_W     = 10,
  parameter int         UPD_DEPTH = 4,
  parameter logic [1:0] INIT_CNT  = DEFAULT_INIT_CNT
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             flush_in,
  output logic             busy_out,
  input  logic             lookup_valid_in,
  input  logic [IDX_W-1:0] lookup_index_in,
  output logic             lookup_ready_out,
  output logic             pred_valid_out,
  output logic             pred_taken_out,
  output logic [1:0]       pred_counter_out,
  input  logic             upd_valid_in,
  input  logic [IDX_W-1:0] upd_index_in,
  input  logic             upd_taken_in,
  output logic             upd_ready_out,
  output logic             mem_en_out,
  output logic             mem_we_out,
  output logic [IDX_W-1:0] mem_addr_out,
  output logic [1:0]       mem_wdata_out,
  input  logic [1:0]       mem_rdata_in
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             run_q;
  logic             pred_valid_q, pred_valid_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [IDX_W:0]   fifo_head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  assign head_idx   = fifo_head[IDX_W-1:0];
  assign head_taken = fifo_head[IDX_W];

  // run_q keeps every RAM/handshake output quiet until the first edge after reset release
  assign busy_out         = (state_q == ST_INIT);
  assign lookup_ready_out = run_q && (state_q == ST_RUN) && !fifo_full && !flush_in;
  assign upd_ready_out    = run_q && (state_q != ST_INIT) && !fifo_full && !flush_in;
  assign fifo_push        = upd_valid_in && upd_ready_out;

  assign pred_valid_out   = pred_valid_q;
  assign pred_counter_out = pred_valid_q ? mem_rdata_in : 2'b00;
  assign pred_taken_out   = pred_counter_out[1];

  bht_upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (IDX_W + 1)
  ) u_upd_fifo (
    .clk_i       (clock_in),
    .rst_ni      (reset_in),
    .clear_i     (flush_in),
    .push_i      (fifo_push),
    .push_data_i ({upd_taken_in, upd_index_in}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    pred_valid_d  = 1'b0;
    fifo_pop      = 1'b0;
    mem_en_out    = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = 2'b00;
    if (flush_in) begin
      state_d = ST_INIT;
      sweep_d = '0;
    end else if (run_q) begin
      case (state_q)
        ST_INIT: begin
          mem_en_out    = 1'b1;
          mem_we_out    = 1'b1;
          mem_addr_out  = sweep_q;
          mem_wdata_out = INIT_CNT;
          sweep_d       = sweep_q + IDX_W'(1);
          if (sweep_q == LAST_IDX) state_d = ST_RUN;
        end
        ST_RUN: begin
          // a full FIFO outranks fetch so updates cannot be starved forever
          if (fifo_full || (!lookup_valid_in && !fifo_empty)) begin
            mem_en_out   = 1'b1;
            mem_addr_out = head_idx;
            state_d      = ST_UPD_WR;
          end else if (lookup_valid_in) begin
            mem_en_out   = 1'b1;
            mem_addr_out = lookup_index_in;
            pred_valid_d = 1'b1;
          end
        end
        ST_UPD_WR: begin
          mem_en_out    = 1'b1;
          mem_we_out    = 1'b1;
          mem_addr_out  = head_idx;
          mem_wdata_out = sat_update(mem_rdata_in, head_taken);
          fifo_pop      = 1'b1;
          state_d       = ST_RUN;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      run_q        <= 1'b0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      run_q        <= 1'b1;
      pred_valid_q <= pred_valid_d;
    end
  end

endmodule

// File: tb/tb_bht_controller.sv
// tb/tb_bht_controller.sv - self-checking bench for bht_controller with behavioural RAM and counter model
module tb_bht_controller;

  localparam int IDX_W    = 10;
  localparam int MEM_SIZE = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             lv = 1'b0;
  logic [IDX_W-1:0] li = '0;
  logic             uv = 1'b0;
  logic [IDX_W-1:0] ui = '0;
  logic             ut = 1'b0;

  logic             busy_out, lookup_ready_out, pred_valid_out, pred_taken_out, upd_ready_out;
  logic [1:0]       pred_counter_out, mem_wdata_out;
  logic             mem_en_out, mem_we_out;
  logic [IDX_W-1:0] mem_addr_out;
  logic [1:0]       rdata_q;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bht_controller dut (
    .clock_in         (clk),
    .reset_in         (rst_n),
    .flush_in         (flush),
    .busy_out         (busy_out),
    .lookup_valid_in  (lv),
    .lookup_index_in  (li),
    .lookup_ready_out (lookup_ready_out),
    .pred_valid_out   (pred_valid_out),
    .pred_taken_out   (pred_taken_out),
    .pred_counter_out (pred_counter_out),
    .upd_valid_in     (uv),
    .upd_index_in     (ui),
    .upd_taken_in     (ut),
    .upd_ready_out    (upd_ready_out),
    .mem_en_out       (mem_en_out),
    .mem_we_out       (mem_we_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_rdata_in     (rdata_q)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Single-port synchronous RAM; fill_req pre-loads garbage so the sweep is observable
  logic [1:0] ram [MEM_SIZE];
  logic       fill_req = 1'b1;
  int         wr_count = 0;
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= 2'b10;
    end else if (mem_en_out) begin
      if (mem_we_out) begin
        ram[mem_addr_out] <= mem_wdata_out;
        wr_count <= wr_count + 1;
      end else begin
        rdata_q <= ram[mem_addr_out];
      end
    end
  end

  function automatic logic [1:0] sat_model(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  // Model: expected table = sweep value with every accepted outcome applied in order
  logic [1:0] gold [MEM_SIZE];
  logic       exp_pv = 1'b0;
  logic [1:0] exp_cnt = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pv = 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) gold[i] = 2'b01;
    end else begin
      chk("pred_valid", pred_valid_out, exp_pv);
      if (exp_pv) begin
        chk("pred_counter", pred_counter_out, exp_cnt);
        chk("pred_taken", pred_taken_out, exp_cnt[1]);
      end
      exp_pv = lv && lookup_ready_out;
      if (exp_pv) exp_cnt = ram[li];
      if (uv && upd_ready_out) gold[ui] = sat_model(gold[ui], ut);
      if (flush) for (int i = 0; i < MEM_SIZE; i++) gold[i] = 2'b01;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, output logic [1:0] cnt, output logic tk);
    bit acc = 1'b0;
    lv = 1'b1;
    li = idx;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = lookup_ready_out;
      @(posedge clk);
      #1;
    end
    lv = 1'b0;
    chk("lookup_accept", acc, 1);
    cnt = pred_counter_out;
    tk  = pred_taken_out;
  endtask

  task automatic do_update(input logic [IDX_W-1:0] idx, input logic tk);
    bit acc = 1'b0;
    uv = 1'b1;
    ui = idx;
    ut = tk;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = upd_ready_out;
      @(posedge clk);
      #1;
    end
    uv = 1'b0;
    chk("upd_accept", acc, 1);
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (busy_out && c < 1100) begin
      tick;
      c++;
    end
  endtask

  task automatic check_ram_all(input string name);
    int bad = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (ram[i] !== gold[i]) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0]       cnt;
    logic             tk;
    int               c, wr0, occ, first_occ, pushes;
    bit               found;
    logic [IDX_W-1:0] u_idx [5] = '{10'd7, 10'd7, 10'd9, 10'd3, 10'd7};
    logic             u_tk  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // reset state
    tick;
    tick;
    fill_req = 1'b0;
    chk("rst_busy", busy_out, 1);
    chk("rst_mem_en", mem_en_out, 0);
    chk("rst_lookup_ready", lookup_ready_out, 0);
    chk("rst_upd_ready", upd_ready_out, 0);
    chk("rst_pred_valid", pred_valid_out, 0);

    // initial sweep
    rst_n = 1'b1;
    tick;
    wr0 = wr_count;
    chk("sweep0_en", mem_en_out, 1);
    chk("sweep0_we", mem_we_out, 1);
    chk("sweep0_addr", mem_addr_out, 0);
    chk("sweep0_wdata", mem_wdata_out, 1);
    count_busy(c);
    chk("init_busy_cycles", c, 1024);
    chk("init_lookup_ready", lookup_ready_out, 1);
    chk("init_writes", wr_count - wr0, 1024);
    check_ram_all("ram_after_init");

    lookup(10'd5, cnt, tk);
    chk("lkp5_init_cnt", cnt, 2'b01);
    chk("lkp5_init_taken", tk, 0);

    // saturation up and down
    repeat (3) do_update(10'd5, 1'b1);
    repeat (12) tick;
    lookup(10'd5, cnt, tk);
    chk("lkp5_3taken_cnt", cnt, 2'b11);
    chk("lkp5_3taken_taken", tk, 1);
    repeat (2) do_update(10'd5, 1'b1);
    repeat (12) tick;
    lookup(10'd5, cnt, tk);
    chk("lkp5_sat_hi", cnt, 2'b11);
    repeat (4) do_update(10'd5, 1'b0);
    repeat (12) tick;
    lookup(10'd5, cnt, tk);
    chk("lkp5_sat_lo", cnt, 2'b00);
    chk("lkp5_sat_lo_taken", tk, 0);

    // lookups every cycle while 5 updates arrive
    occ = 0;
    first_occ = -1;
    pushes = 0;
    wr0 = wr_count;
    lv = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      li = 10'd100 + cyc[IDX_W-1:0];
      if (pushes < 5) begin
        uv = 1'b1;
        ui = u_idx[pushes];
        ut = u_tk[pushes];
      end else begin
        uv = 1'b0;
      end
      @(negedge clk);
      if (!lookup_ready_out && first_occ < 0) first_occ = occ;
      if (uv && upd_ready_out) begin
        occ++;
        pushes++;
      end
      if (mem_en_out && mem_we_out) occ--;
      @(posedge clk);
      #1;
    end
    lv = 1'b0;
    uv = 1'b0;
    repeat (12) tick;
    chk("fifo_depth_at_block", first_occ, 4);
    chk("stress_pushes", pushes, 5);
    chk("stress_writes", wr_count - wr0, 5);
    check_ram_all("ram_after_stress");

    // flush during UPD_WR with two more updates queued
    lv = 1'b1;
    li = 10'd40;
    pushes = 0;
    for (int cyc = 0; cyc < 20 && pushes < 3; cyc++) begin
      uv = 1'b1;
      ui = 10'd20 + 10'(pushes);
      ut = 1'b1;
      @(negedge clk);
      if (upd_ready_out) pushes++;
      @(posedge clk);
      #1;
    end
    uv = 1'b0;
    lv = 1'b0;
    chk("flush_pushes", pushes, 3);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (mem_en_out && !mem_we_out) found = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("flush_rmw_read_seen", found, 1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_write_dropped", mem_en_out, 0);
    chk("flush_lookup_ready", lookup_ready_out, 0);
    chk("flush_upd_ready", upd_ready_out, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr0 = wr_count;
    count_busy(c);
    chk("flush_busy_cycles", c, 1024);
    c = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_en_out) c++;
      @(posedge clk);
      #1;
    end
    chk("flush_fifo_empty_idle", c, 0);
    chk("flush_sweep_writes", wr_count - wr0, 1024);
    check_ram_all("ram_after_flush");

    // lookup issued the cycle before a flush still returns a prediction
    lookup(10'd77, cnt, tk);
    flush = 1'b1;
    chk("pred_across_flush", pred_valid_out, 1);
    chk("pred_across_flush_cnt", cnt, 2'b01);
    tick;
    flush = 1'b0;

    // reset in the middle of the sweep
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (mem_en_out && mem_we_out && mem_addr_out == 10'd300) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("sweep_reached_300", found, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en_out, 0);
    chk("midrst_mem_we", mem_we_out, 0);
    chk("midrst_addr", mem_addr_out, 0);
    chk("midrst_busy", busy_out, 1);
    chk("midrst_upd_ready", upd_ready_out, 0);
    chk("midrst_pred_valid", pred_valid_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    chk("restart_addr", mem_addr_out, 0);
    chk("restart_en", mem_en_out, 1);
    count_busy(c);
    chk("restart_busy_cycles", c, 1024);
    lookup(10'd300, cnt, tk);
    chk("lkp300_after_restart", cnt, 2'b01);
    check_ram_all("ram_after_restart");

    repeat (3) tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
